// File: rtl/btn_input_ctrl_pkg.sv
// Shared types and constants for the push-button / switch capture block.
// Holds the debounce FSM state type and the rd_data field layout.
package btn_input_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    CHECK_PRESS   = 2'd1,
    HELD          = 2'd2,
    CHECK_RELEASE = 2'd3
  } btn_state_e;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int OVERRUN_BIT             = 31;
  localparam int SW_LSB                  = 0;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to all zeros.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_input_ctrl.sv
// Debounced push-button that strobes a CPU "continue" and captures the
// switch bank into a single-entry read register with a sticky overrun flag.
module btn_input_ctrl
  import btn_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                btn_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  input  logic                rd_ack,
  output logic                cont_pulse,
  output logic                rd_valid,
  output logic [31:0]         rd_data,
  output logic                btn_level,
  output btn_state_e          dbg_state
);

  // Read handshake: rd_valid high means rd_data holds an unread capture; the
  // consumer pulses rd_ack for one cycle to take it, and an ack seen while
  // rd_valid is low does nothing.

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  // The entry cycle counts as the first stable sample, so acceptance fires
  // when the count is about to reach DEBOUNCE_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = (DEBOUNCE_CYCLES >= 2) ? CW'(DEBOUNCE_CYCLES - 2) : '0;

  logic                btn_sync;
  logic [SW_WIDTH-1:0] sw_sync;

  sync2 #(.W(1)) u_sync_btn (
    .clk    (clk),
    .nreset (nreset),
    .d_i    (btn_raw),
    .q_o    (btn_sync)
  );

  sync2 #(.W(SW_WIDTH)) u_sync_sw (
    .clk    (clk),
    .nreset (nreset),
    .d_i    (sw_raw),
    .q_o    (sw_sync)
  );

  btn_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                done;
  logic                capture;
  logic                pulse_q;
  logic                valid_q;
  logic                overrun_q;
  logic [SW_WIDTH-1:0] data_q;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign done    = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = CHECK_PRESS;
          cnt_d   = '0;
        end
      end
      CHECK_PRESS: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = HELD;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_d = CHECK_RELEASE;
          cnt_d   = '0;
        end
      end
      CHECK_RELEASE: begin
        if (btn_sync) begin
          state_d = HELD;
        end else if (done) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A fresh capture beats a same-cycle ack: the new word is unread.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pulse_q   <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
    end else begin
      pulse_q <= capture;
      if (capture) begin
        data_q    <= sw_sync;
        valid_q   <= 1'b1;
        overrun_q <= valid_q && !rd_ack;
      end else if (rd_ack && valid_q) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data                       = '0;
    rd_data[SW_LSB +: SW_WIDTH]   = data_q;
    rd_data[OVERRUN_BIT]          = overrun_q;
  end

  assign cont_pulse = pulse_q;
  assign rd_valid   = valid_q;
  assign btn_level  = (state_q == HELD) || (state_q == CHECK_RELEASE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Directed bench for btn_input_ctrl with a short debounce window; captured
// words are predicted into a queue at press time and checked on each pulse.
module tb_btn_input_ctrl;
  import btn_input_ctrl_pkg::*;

  localparam int DB = 4;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          nreset;
  logic          btn_raw;
  logic [SW-1:0] sw_raw;
  logic          rd_ack;
  logic          cont_pulse;
  logic          rd_valid;
  logic [31:0]   rd_data;
  logic          btn_level;
  btn_state_e    dbg_state;

  btn_input_ctrl #(.DEBOUNCE_CYCLES(DB), .SW_WIDTH(SW)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .btn_raw    (btn_raw),
    .sw_raw     (sw_raw),
    .rd_ack     (rd_ack),
    .cont_pulse (cont_pulse),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .btn_level  (btn_level),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  int pulse_cyc = -1;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard: every pulse must match the oldest predicted capture
  always @(negedge clk) begin
    if (nreset === 1'b1 && cont_pulse === 1'b1) begin
      pulse_cnt++;
      pulse_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_pulse", 32'd1, 32'd0);
      else                   check("capture_data", rd_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int c0;
  int p0;
  logic lvl_ok;

  initial begin
    nreset  = 1'b0;
    btn_raw = 1'b0;
    sw_raw  = '0;
    rd_ack  = 1'b0;
    step(3);
    check("rst_pulse", 32'(cont_pulse), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", rd_data, 32'd0);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    nreset = 1'b1;
    step(2);

    // clean press: one pulse 2 sync + 4 stable cycles after the edge
    sw_raw = 16'hA5A5;
    exp_q.push_back(32'h0000A5A5);
    c0 = cyc;
    btn_raw = 1'b1;
    step(10);
    check("press_latency", 32'(pulse_cyc - c0), 32'd6);
    check("press_count", 32'(pulse_cnt), 32'd1);
    check("press_valid", 32'(rd_valid), 32'd1);
    check("press_data", rd_data, 32'h0000A5A5);
    check("press_level", 32'(btn_level), 32'd1);
    btn_raw = 1'b0;
    step(8);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    check("ack1_valid", 32'(rd_valid), 32'd0);

    // bounce: toggling every 2 cycles never settles
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      btn_raw = ~btn_raw;
      step(2);
    end
    btn_raw = 1'b0;
    step(8);
    check("bounce_count", 32'(pulse_cnt - p0), 32'd0);
    check("bounce_valid", 32'(rd_valid), 32'd0);

    // two presses with no ack: overrun set, data overwritten
    sw_raw = 16'h0001;
    exp_q.push_back(32'h00000001);
    btn_raw = 1'b1; step(8); btn_raw = 1'b0; step(8);
    sw_raw = 16'h0002;
    exp_q.push_back(32'h80000002);
    btn_raw = 1'b1; step(8); btn_raw = 1'b0; step(8);
    check("ovr_data", rd_data, 32'h80000002);
    check("ovr_valid", 32'(rd_valid), 32'd1);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    check("ovr_ack_valid", 32'(rd_valid), 32'd0);
    check("ovr_ack_data", rd_data, 32'h00000002);

    // ack coincident with a capture while valid: capture wins, no overrun
    sw_raw = 16'h0003;
    exp_q.push_back(32'h00000003);
    btn_raw = 1'b1; step(8); btn_raw = 1'b0; step(8);
    sw_raw = 16'h0004;
    exp_q.push_back(32'h00000004);
    btn_raw = 1'b1;
    step(5);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    check("race_valid", 32'(rd_valid), 32'd1);
    check("race_data", rd_data, 32'h00000004);
    btn_raw = 1'b0;
    step(8);
    rd_ack = 1'b1; step(1); rd_ack = 1'b0;
    check("race_ack_valid", 32'(rd_valid), 32'd0);
    rd_ack = 1'b1; step(1); rd_ack = 1'b0;
    check("idle_ack_valid", 32'(rd_valid), 32'd0);
    check("idle_ack_data", rd_data, 32'h00000004);

    // reset during CHECK_PRESS with button held
    sw_raw = 16'h0005;
    btn_raw = 1'b1;
    step(4);
    check("pre_rst_state", 32'(dbg_state), 32'(CHECK_PRESS));
    nreset = 1'b0;
    #1;
    check("mid_rst_pulse", 32'(cont_pulse), 32'd0);
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_data", rd_data, 32'd0);
    check("mid_rst_level", 32'(btn_level), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    step(2);
    p0 = pulse_cnt;
    exp_q.push_back(32'h00000005);
    nreset = 1'b1;
    c0 = cyc;

    // long hold: one pulse, level stays high until release settles
    lvl_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if ((cyc - c0) >= 6 && btn_level !== 1'b1) lvl_ok = 1'b0;
    end
    check("rst_latency", 32'(pulse_cyc - c0), 32'd6);
    check("hold_count", 32'(pulse_cnt - p0), 32'd1);
    check("hold_level", 32'(lvl_ok), 32'd1);
    btn_raw = 1'b0;
    step(5);
    check("release5_level", 32'(btn_level), 32'd1);
    step(1);
    check("release6_level", 32'(btn_level), 32'd0);
    step(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_input_ctrl.md
BTN_INPUT_CTRL -- requirements
Module: btn_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning cycles a synchronized input must stay stable before acceptance (10 ms at 100 MHz).
REQ-002 SHALL have parameter SW_WIDTH, default 16, meaning width of the switch bank.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 nreset  input  1  asynchronous, active-low reset.
REQ-005 btn_raw  input  1  raw asynchronous push-button, active-high.
REQ-006 sw_raw  input  SW_WIDTH  raw asynchronous slide switches.
REQ-007 rd_ack  input  1  CPU consumed rd_data this cycle.
REQ-008 cont_pulse  output  1  one-cycle strobe per accepted press (drives CPU continue).
REQ-009 rd_valid  output  1  rd_data holds an unread capture.
REQ-010 rd_data  output  32  {overrun, 15'b0, captured switches}, zero-extended to 32 bits.
REQ-011 btn_level  output  1  debounced button level.

Function
REQ-012 btn_raw and sw_raw SHALL each pass a 2-flop synchronizer before any other use; synchronizer latency is 2 cycles.
REQ-013 Debounce FSM SHALL have states IDLE, CHECK_PRESS, HELD, CHECK_RELEASE.
REQ-014 IDLE -> CHECK_PRESS when sync button = 1; counter cleared.
REQ-015 CHECK_PRESS: counter increments while sync = 1; sync = 0 -> IDLE; counter reaching DEBOUNCE_CYCLES-1 with sync = 1 -> HELD.
REQ-016 On CHECK_PRESS->HELD, cont_pulse SHALL be 1 for exactly the next cycle, and sync switches SHALL be captured in the same cycle.
REQ-017 HELD -> CHECK_RELEASE when sync = 0; CHECK_RELEASE returns to HELD on sync = 1, or goes to IDLE after DEBOUNCE_CYCLES stable-low cycles.
REQ-018 btn_level = 1 in HELD and CHECK_RELEASE, else 0.
REQ-019 Counter width SHALL be clog2(DEBOUNCE_CYCLES); counter SHALL saturate and never wrap.
REQ-020 Holding a button SHALL produce exactly one cont_pulse; the next pulse requires passing through IDLE.
REQ-021 Capture SHALL set rd_valid = 1; rd_ack while rd_valid = 1 SHALL clear rd_valid and overrun the next cycle.
REQ-022 Capture while rd_valid = 1 SHALL overwrite data and set overrun = 1 (sticky until ack).
REQ-023 Capture and rd_ack in the same cycle: capture wins; rd_valid stays 1, new data, overrun = 0.
REQ-024 rd_ack while rd_valid = 0 SHALL be ignored.
REQ-025 rd_data SHALL stay stable while rd_valid = 1 and no capture occurs.

Reset
REQ-026 nreset low SHALL immediately force FSM = IDLE, counter = 0, synchronizers = 0, cont_pulse = 0, rd_valid = 0, rd_data = 0, btn_level = 0.
REQ-027 Reset mid-debounce or with button held SHALL emit no pulse; a held button after release of reset SHALL debounce afresh and pulse once.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef, the rd_data field offsets (OVERRUN_BIT = 31), and the DEBOUNCE_CYCLES default.
REQ-029 The synchronizer SHALL be a sub-module sync2 (parameterized width), instantiated for the button and for the switches.

Verification (DEBOUNCE_CYCLES = 4)
REQ-030 btn high 10 cycles, sw = 16'hA5A5 -> exactly one cont_pulse at cycle 2+4; rd_valid = 1; rd_data = 32'h0000A5A5.
REQ-031 btn toggles every 2 cycles for 20 cycles -> no cont_pulse; rd_valid stays 0.
REQ-032 Two clean presses, no ack, sw 16'h0001 then 16'h0002 -> rd_data = 32'h80000002; rd_ack -> rd_valid = 0 next cycle.
REQ-033 rd_ack asserted in the same cycle as a capture -> rd_valid stays 1; bit 31 = 0; new switch value.
REQ-034 nreset pulsed low during CHECK_PRESS with button held -> outputs zero at once; one pulse 6 cycles after reset release.
REQ-035 Button held 1000 cycles -> exactly one cont_pulse; btn_level = 1 throughout, 0 after 6 cycles of release.
